// File: rtl/uart_i2c_usb_sel_ctrl.sv
// Sequencer that owns the shared-pin UART/I2C/USB select: drains the active
// peripheral, tri-states the pads around the select change, then releases them.
module uart_i2c_usb_sel_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 1000,
    parameter logic [7:0]  GUARD_DEF     = 8'd8
) (
    input  logic        app_clk,
    input  logic        arst_n,
    input  logic        reg_cs,
    input  logic        reg_wr,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_be,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    input  logic        uart_idle,
    input  logic        i2c_idle,
    input  logic        usb_idle,
    output logic [1:0]  uart_i2c_usb_sel,
    output logic        pad_hold,
    output logic        sel_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_HOLD,
        ST_SWITCH,
        ST_SETTLE
    } state_t;

    localparam logic [15:0] DRAIN_LIM = 16'(DRAIN_TIMEOUT);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_GUARD  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  cur_sel_q, cur_sel_d;
    logic [1:0]  tgt_q, tgt_d;
    logic        force_q, force_d;
    logic [7:0]  glen_q, glen_d;
    logic [7:0]  guard_q, guard_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic        tout_err_q, tout_err_d;
    logic        inv_err_q, inv_err_d;
    logic        pad_hold_q, pad_hold_d;
    logic        sel_done_q, sel_done_d;
    logic        reg_ack_q, reg_ack_d;
    logic [31:0] reg_rdata_q, reg_rdata_d;

    logic        accept;
    logic        wr_acc;
    logic        rd_acc;
    logic        busy;
    logic        cur_idle;
    logic        glen_last;
    logic [31:0] rd_val;
    logic        unused_ok;

    assign unused_ok = ^reg_wdata[31:8];

    assign accept    = reg_cs && !reg_ack_q;
    assign wr_acc    = accept && reg_wr && reg_be;
    assign rd_acc    = accept && !reg_wr;
    assign busy      = (state_q != ST_IDLE);
    assign glen_last = (cnt_q == 8'(glen_q - 8'd1));

    always_comb begin
        cur_idle = 1'b1;
        case (cur_sel_q)
            2'b00:   cur_idle = uart_idle;
            2'b01:   cur_idle = i2c_idle;
            2'b10:   cur_idle = usb_idle;
            default: cur_idle = 1'b1;
        endcase
    end

    always_comb begin
        rd_val = 32'h0;
        case (reg_addr)
            ADDR_CTRL:   rd_val = {29'h0, busy, cur_sel_q};
            ADDR_GUARD:  rd_val = {24'h0, guard_q};
            ADDR_STATUS: rd_val = {27'h0, inv_err_q, tout_err_q, cur_sel_q, busy};
            default:     rd_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        tgt_d       = tgt_q;
        force_d     = force_q;
        glen_d      = glen_q;
        guard_d     = guard_q;
        cnt_d       = cnt_q;
        drain_cnt_d = drain_cnt_q;
        tout_err_d  = tout_err_q;
        inv_err_d   = inv_err_q;
        sel_done_d  = 1'b0;
        reg_ack_d   = accept;
        reg_rdata_d = rd_acc ? rd_val : 32'h0;

        if (wr_acc && (reg_addr == ADDR_GUARD)) begin
            guard_d = reg_wdata[7:0];
        end

        // Clears are applied first so that a same-cycle error event wins.
        if (wr_acc && (reg_addr == ADDR_STATUS)) begin
            if (reg_wdata[3]) tout_err_d = 1'b0;
            if (reg_wdata[4]) inv_err_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_acc && (reg_addr == ADDR_CTRL)) begin
                    if (reg_wdata[1:0] == 2'b11) begin
                        inv_err_d = 1'b1;
                    end else if (reg_wdata[1:0] != cur_sel_q) begin
                        tgt_d       = reg_wdata[1:0];
                        force_d     = reg_wdata[2];
                        glen_d      = (guard_q == 8'd0) ? 8'd1 : guard_q;
                        drain_cnt_d = 16'd0;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cur_idle) begin
                    cnt_d   = 8'd0;
                    state_d = ST_HOLD;
                end else begin
                    drain_cnt_d = drain_cnt_q + 16'd1;
                    if (drain_cnt_d == DRAIN_LIM) begin
                        tout_err_d = 1'b1;
                        cnt_d      = 8'd0;
                        state_d    = force_q ? ST_HOLD : ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (glen_last) begin
                    cnt_d   = 8'd0;
                    state_d = ST_SWITCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SWITCH: begin
                cur_sel_d = tgt_q;
                cnt_d     = 8'd0;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (glen_last) begin
                    cnt_d      = 8'd0;
                    sel_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Derived from the next state so the pads are held from the first HOLD cycle.
        pad_hold_d = (state_d == ST_HOLD) || (state_d == ST_SWITCH) ||
                     (state_d == ST_SETTLE);
    end

    always_ff @(posedge app_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            cur_sel_q   <= 2'b00;
            tgt_q       <= 2'b00;
            force_q     <= 1'b0;
            glen_q      <= 8'd1;
            guard_q     <= GUARD_DEF;
            cnt_q       <= 8'd0;
            drain_cnt_q <= 16'd0;
            tout_err_q  <= 1'b0;
            inv_err_q   <= 1'b0;
            pad_hold_q  <= 1'b0;
            sel_done_q  <= 1'b0;
            reg_ack_q   <= 1'b0;
            reg_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            tgt_q       <= tgt_d;
            force_q     <= force_d;
            glen_q      <= glen_d;
            guard_q     <= guard_d;
            cnt_q       <= cnt_d;
            drain_cnt_q <= drain_cnt_d;
            tout_err_q  <= tout_err_d;
            inv_err_q   <= inv_err_d;
            pad_hold_q  <= pad_hold_d;
            sel_done_q  <= sel_done_d;
            reg_ack_q   <= reg_ack_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

    assign uart_i2c_usb_sel = cur_sel_q;
    assign pad_hold         = pad_hold_q;
    assign sel_done         = sel_done_q;
    assign reg_ack          = reg_ack_q;
    assign reg_rdata        = reg_rdata_q;

endmodule

// File: tb/tb_uart_i2c_usb_sel_ctrl.sv
// Bench for uart_i2c_usb_sel_ctrl: register vector table, scoreboarded reg
// responses, and cycle-exact switch timelines including drain, timeout and reset.
module tb_uart_i2c_usb_sel_ctrl;

    localparam int DT = 20;

    logic        app_clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        reg_cs = 1'b0;
    logic        reg_wr = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic [31:0] reg_wdata = 32'h0;
    logic        reg_be = 1'b0;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        uart_idle = 1'b1;
    logic        i2c_idle = 1'b1;
    logic        usb_idle = 1'b1;
    logic [1:0]  sel;
    logic        pad_hold;
    logic        sel_done;

    uart_i2c_usb_sel_ctrl #(.DRAIN_TIMEOUT(DT), .GUARD_DEF(8'd8)) dut (
        .app_clk          (app_clk),
        .arst_n           (arst_n),
        .reg_cs           (reg_cs),
        .reg_wr           (reg_wr),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_be           (reg_be),
        .reg_rdata        (reg_rdata),
        .reg_ack          (reg_ack),
        .uart_idle        (uart_idle),
        .i2c_idle         (i2c_idle),
        .usb_idle         (usb_idle),
        .uart_i2c_usb_sel (sel),
        .pad_hold         (pad_hold),
        .sel_done         (sel_done)
    );

    always #5 app_clk = ~app_clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        forever begin
            @(posedge app_clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard consumer: every ack pops the response predicted at drive time.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge app_clk);
            if (arst_n) begin
                if (reg_ack) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_ack", 32'h1, 32'h0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rdata", reg_rdata, e);
                    end
                end else begin
                    chk("rdata_idle_zero", reg_rdata, 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge app_clk);
            #1;
        end
    endtask

    task automatic access(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                          input logic be, input logic [31:0] exp, output int t_acc);
        int n;
        if (reg_ack) step(1);
        reg_cs    = 1'b1;
        reg_wr    = wr;
        reg_addr  = addr;
        reg_wdata = wdata;
        reg_be    = be;
        sb_q.push_back(wr ? 32'h0 : exp);
        t_acc = cyc;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!reg_ack && n < 8);
        chk("ack_latency", n, 1);
        reg_cs = 1'b0;
        reg_be = 1'b0;
    endtask

    // Expected outputs every cycle of a switch accepted at t, drain extended by d.
    task automatic run_switch(input int t, input int g, input int d, input logic [1:0] old_sel,
                              input logic [1:0] new_sel, input bit raise_i2c, input bit mid);
        int hold_start;
        int sel_at;
        int done;
        hold_start = t + 2 + d;
        sel_at     = t + 3 + d + g;
        done       = t + 3 + d + 2 * g;
        for (int k = t + 1; k <= done + 1; k++) begin
            if (raise_i2c && k == t + 1 + d) i2c_idle = 1'b1;
            if (mid) begin
                if (k == t + 3) begin
                    reg_cs = 1'b1; reg_wr = 1'b1; reg_be = 1'b1;
                    reg_addr = 2'd1; reg_wdata = 32'h2;
                    sb_q.push_back(32'h0);
                end else if (k == t + 5) begin
                    reg_cs = 1'b1; reg_wr = 1'b1; reg_be = 1'b1;
                    reg_addr = 2'd0; reg_wdata = 32'h0;
                    sb_q.push_back(32'h0);
                end else if (k == t + 4 || k == t + 6) begin
                    reg_cs = 1'b0;
                end
            end
            chk("pad_hold", pad_hold, (k >= hold_start && k < done) ? 1 : 0);
            chk("sel", sel, (k >= sel_at) ? new_sel : old_sel);
            chk("sel_done", sel_done, (k == done) ? 1 : 0);
            step(1);
        end
    endtask

    initial begin
        int t;
        arst_n = 1'b0;
        step(3);
        chk("rst_sel", sel, 0);
        chk("rst_pad_hold", pad_hold, 0);
        chk("rst_sel_done", sel_done, 0);
        chk("rst_ack", reg_ack, 0);
        chk("rst_rdata", reg_rdata, 0);
        arst_n = 1'b1;
        step(1);

        tbl.push_back('{1'b0, 2'd0, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd1, 32'h0,        1'b1, 32'h8});
        tbl.push_back('{1'b0, 2'd2, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'd3, 32'hFFFFFFFF, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd3, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'd1, 32'h1FF,      1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd1, 32'h0,        1'b1, 32'hFF});
        tbl.push_back('{1'b1, 2'd1, 32'h4,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'd1, 32'h9,        1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd1, 32'h0,        1'b1, 32'h4});
        tbl.push_back('{1'b1, 2'd0, 32'h3,        1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0,        1'b1, 32'h10});
        tbl.push_back('{1'b0, 2'd0, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'd2, 32'h10,       1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'd0, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'd0, 32'h0,        1'b1, 32'h0});
        foreach (tbl[i]) begin
            access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp, t);
            $display("vec %0d wr=%0b addr=%0d wdata=%0h be=%0b exp=%0h", i,
                     tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp);
        end
        chk("noop_busy", pad_hold, 0);

        // UART -> I2C, G=4, peripheral already idle
        access(1'b1, 2'd0, 32'h1, 1'b1, 32'h0, t);
        run_switch(t, 4, 0, 2'd0, 2'd1, 1'b0, 1'b0);
        access(1'b0, 2'd2, 32'h0, 1'b1, 32'h2, t);
        $display("switch uart->i2c done");

        // I2C busy, no force: times out after DT drain cycles with no switch
        i2c_idle = 1'b0;
        access(1'b1, 2'd0, 32'h2, 1'b1, 32'h0, t);
        for (int k = t + 1; k < t + DT; k++) begin
            chk("tout_pad_hold", pad_hold, 0);
            chk("tout_sel_done", sel_done, 0);
            step(1);
        end
        access(1'b0, 2'd2, 32'h0, 1'b1, 32'h3, t);
        access(1'b0, 2'd2, 32'h0, 1'b1, 32'hA, t);
        chk("tout_sel", sel, 1);
        chk("tout_pad_hold_after", pad_hold, 0);
        access(1'b1, 2'd2, 32'h8, 1'b1, 32'h0, t);
        access(1'b0, 2'd2, 32'h0, 1'b1, 32'h2, t);
        $display("timeout without force done");

        // Forced switch after timeout: HOLD starts at t+DT+1
        access(1'b1, 2'd0, 32'h6, 1'b1, 32'h0, t);
        run_switch(t, 4, DT - 1, 2'd1, 2'd2, 1'b0, 1'b0);
        access(1'b0, 2'd2, 32'h0, 1'b1, 32'hC, t);
        access(1'b1, 2'd2, 32'h18, 1'b1, 32'h0, t);
        access(1'b0, 2'd2, 32'h0, 1'b1, 32'h4, t);
        i2c_idle = 1'b1;
        $display("forced switch i2c->usb done");

        // USB -> I2C with GUARD rewrite and a busy CTRL write mid-switch
        access(1'b1, 2'd0, 32'h1, 1'b1, 32'h0, t);
        run_switch(t, 4, 0, 2'd2, 2'd1, 1'b0, 1'b1);
        access(1'b0, 2'd1, 32'h0, 1'b1, 32'h2, t);
        access(1'b0, 2'd2, 32'h0, 1'b1, 32'h2, t);
        $display("latched guard and busy write done");

        // I2C -> UART with idle arriving 5 cycles late, G=2
        i2c_idle = 1'b0;
        access(1'b1, 2'd0, 32'h0, 1'b1, 32'h0, t);
        run_switch(t, 2, 5, 2'd1, 2'd0, 1'b1, 1'b0);
        $display("late idle switch done");

        // UART -> I2C, then reset in the middle of I2C -> USB HOLD
        access(1'b1, 2'd0, 32'h1, 1'b1, 32'h0, t);
        run_switch(t, 2, 0, 2'd0, 2'd1, 1'b0, 1'b0);
        access(1'b1, 2'd0, 32'h2, 1'b1, 32'h0, t);
        step(2);
        chk("hold_before_rst", pad_hold, 1);
        chk("sel_before_rst", sel, 1);
        arst_n = 1'b0;
        #1;
        chk("async_rst_pad_hold", pad_hold, 0);
        chk("async_rst_sel", sel, 0);
        chk("async_rst_ack", reg_ack, 0);
        chk("async_rst_sel_done", sel_done, 0);
        step(2);
        arst_n = 1'b1;
        step(1);
        access(1'b0, 2'd1, 32'h0, 1'b1, 32'h8, t);
        access(1'b0, 2'd2, 32'h0, 1'b1, 32'h0, t);
        $display("async reset mid-hold done");

        access(1'b1, 2'd1, 32'h3, 1'b1, 32'h0, t);
        access(1'b1, 2'd0, 32'h2, 1'b1, 32'h0, t);
        run_switch(t, 3, 0, 2'd0, 2'd2, 1'b0, 1'b0);
        $display("post-reset switch uart->usb done");

        // GUARD=0 behaves as a one-cycle guard
        access(1'b1, 2'd1, 32'h0, 1'b1, 32'h0, t);
        access(1'b1, 2'd0, 32'h0, 1'b1, 32'h0, t);
        run_switch(t, 1, 0, 2'd2, 2'd0, 1'b0, 1'b0);
        access(1'b0, 2'd2, 32'h0, 1'b1, 32'h0, t);
        $display("guard zero switch done");

        step(2);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_i2c_usb_sel_ctrl.md
# uart_i2c_usb_sel_ctrl

Register-programmed sequencer that owns the 2-bit UART/I2C/USB interface select driving the shared two-pin peripheral block. Software requests a new interface; the block waits for the active peripheral to go idle, holds both pads tri-stated for a guard interval, switches the select, then holds the pads again for a settle interval before releasing them. This removes glitches on shared pins (TXD/SDA/DP, RXD/SCL/DN) when the active interface changes. It sits on the same reg bus as the peripheral block, in the app_clk domain.

## Interface
- DRAIN_TIMEOUT, 1000: maximum cycles spent waiting for the active peripheral to become idle (16-bit counter).
- GUARD_DEF, 8: reset value of the GUARD register (cycles).

Ports:
- app_clk  in  1  block clock; single clock domain.
- arst_n  in  1  asynchronous active-low reset.
- reg_cs  in  1  register access strobe; held until reg_ack.
- reg_wr  in  1  1 = write, 0 = read.
- reg_addr  in  2  register select.
- reg_wdata  in  32  write data.
- reg_be  in  1  byte enable; writes take effect only when 1.
- reg_rdata  out  32  read data, valid with reg_ack.
- reg_ack  out  1  single-cycle access acknowledge.
- uart_idle, i2c_idle, usb_idle  in  1 each  peripheral has no transfer in progress.
- uart_i2c_usb_sel  out  2  interface select: 00 UART, 01 I2C, 10 USB.
- pad_hold  out  1  forces both pad io_oeb high (tri-state) at the pad mux.
- sel_done  out  1  one-cycle pulse when a switch completes.

## Operation
- Registers:
  - addr 0, CTRL: write bits[1:0] = target select, bit[2] = force; writing starts a switch. Read returns {29'h0, busy, cur_sel}.
  - addr 1, GUARD: bits[7:0] guard cycle count, R/W.
  - addr 2, STATUS: bit0 busy, bits[2:1] cur_sel, bit3 timeout_err (sticky), bit4 inv_err (sticky). Writing 1 to bit3 or bit4 clears it.
  - addr 3: reads 0; writes ignored.
- FSM states: IDLE, DRAIN, HOLD, SWITCH, SETTLE.
- IDLE -> DRAIN on an accepted CTRL write with a valid target different from cur_sel.
- A target equal to cur_sel is a no-op; it is acked with no state change.
- A target of 2'b11 sets inv_err and is otherwise ignored.
- A CTRL write while busy (state != IDLE) is acked and ignored.
- DRAIN:
  - cur_idle is the idle input selected by cur_sel.
  - If cur_idle=1, go to HOLD.
  - Otherwise increment the drain counter. When it reaches DRAIN_TIMEOUT, set timeout_err.
  - On timeout with force=1, go to HOLD. On timeout with force=0, return to IDLE with no switch and no sel_done.
- HOLD: pad_hold=1 for G cycles, then go to SWITCH. G = GUARD[7:0], and GUARD=0 is treated as G=1.
- SWITCH: one cycle. cur_sel <= target and pad_hold stays 1. Then go to SETTLE.
- SETTLE: pad_hold=1 for G cycles, then go to IDLE and pulse sel_done.
- busy = (state != IDLE).
- uart_i2c_usb_sel is driven directly from the cur_sel register.
- The guard value is latched when the CTRL write is accepted. Writing GUARD mid-switch does not affect the switch in progress.

## Timing
- A reg access is accepted in cycle T when reg_cs=1 and reg_ack=0.
- reg_ack=1 in T+1 and 0 in T+2, even if reg_cs is still high.
- reg_rdata is registered and valid in T+1; it is 0 whenever reg_ack=0.
- Switch timeline after a CTRL write accepted at T, with cur_idle already 1:
  - DRAIN at T+1, HOLD at T+2..T+1+G, SWITCH at T+2+G.
  - New uart_i2c_usb_sel visible at T+3+G.
  - SETTLE at T+3+G..T+2+2G.
  - IDLE, pad_hold=0 and sel_done=1 at T+3+2G.
- pad_hold is registered and rises at T+2.
- pad_hold is never 0 in the cycle where uart_i2c_usb_sel changes, nor for G cycles before or after it.
- Reset values: uart_i2c_usb_sel=00, pad_hold=0, sel_done=0, reg_ack=0, reg_rdata=0, busy=0, errors=0, GUARD=GUARD_DEF, drain counter=0, state IDLE.
- Reset asserted mid-switch returns all outputs to their reset values immediately (asynchronous), including sel=00.
- If an error-clear write and an error-set event occur in the same cycle, the set wins.

## Test plan
- Reset, then read CTRL -> reg_rdata=0, sel=00, pad_hold=0; read GUARD -> 8.
- GUARD=4, uart_idle=1, write CTRL=1 at T -> pad_hold high T+2..T+10, sel=01 at T+7, sel_done pulse at T+11, STATUS=0x2.
- sel=I2C, i2c_idle=0 held, DRAIN_TIMEOUT=20, write CTRL=2 (force=0) -> timeout_err=1 after 20 cycles, sel stays 01, no sel_done, pad_hold never asserted; repeat with CTRL=6 (force=1) -> switch completes to 10.
- i2c_idle=0, then raised 5 cycles after the CTRL write -> HOLD begins the cycle after idle is seen; total latency extends by exactly 5 cycles.
- Write CTRL=3 -> inv_err=1, no state change; write STATUS=0x10 -> inv_err cleared. Write CTRL=0 while sel=00 -> acked, busy stays 0.
- Assert arst_n low during HOLD -> pad_hold=0 and sel=00 immediately; after release, a new switch runs normally. Write CTRL while busy -> ignored, target unchanged.
